// File: rtl/logip_pkg.sv
// Shared types and helpers for the logic-analyser capture controller.
package logip_pkg;

    localparam int unsigned CNT_WIDTH_DEF = 16;
    localparam int unsigned CMD_WIDTH     = 2 * CNT_WIDTH_DEF;
    localparam int unsigned EXP_WIDTH     = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_POST    = 3'd2,
        ST_RD      = 3'd3,
        ST_TX_STB  = 3'd4,
        ST_TX_BUSY = 3'd5,
        ST_TX_WAIT = 3'd6
    } cap_state_e;

    // Sample count for a programmed field: (n+1)*4, computed wide so callers truncate safely.
    function automatic logic [EXP_WIDTH-1:0] expand_cnt(input logic [EXP_WIDTH-1:0] n);
        return (n + EXP_WIDTH'(1)) << 2;
    endfunction

endpackage

// File: rtl/logip_capture_ctrl_if.sv
// Command, sampler, RAM and transmitter signals of the capture controller.
interface logip_capture_ctrl_if #(
    parameter int unsigned DEPTH     = 5,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                     set_cnt_i;
    logic [2*CNT_WIDTH-1:0]   cmd_i;
    logic                     arm_i;
    logic                     abort_i;
    logic                     run_i;
    logic                     stb_i;
    logic                     we_o;
    logic [DEPTH-1:0]         addr_o;
    logic                     tx_rdy_i;
    logic                     tx_stb_o;
    logic                     tx_sel_o;
    logic                     busy_o;
    logic                     armed_o;
    logic                     done_o;

    modport master (
        output set_cnt_i, cmd_i, arm_i, abort_i, run_i, stb_i, tx_rdy_i,
        input  we_o, addr_o, tx_stb_o, tx_sel_o, busy_o, armed_o, done_o
    );

    modport slave (
        input  set_cnt_i, cmd_i, arm_i, abort_i, run_i, stb_i, tx_rdy_i,
        output we_o, addr_o, tx_stb_o, tx_sel_o, busy_o, armed_o, done_o
    );
endinterface

// File: rtl/logip_sat_cnt.sv
// Up-counter that sticks at 2^DEPTH; tracks how much of the ring holds valid samples.
module logip_sat_cnt #(
    parameter int unsigned DEPTH = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           inc,
    output logic [DEPTH:0] count
);
    localparam int unsigned W = DEPTH + 1;

    // The top bit is only ever set at exactly 2^DEPTH, so it doubles as the full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !count[DEPTH]) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/logip_capture_ctrl.sv
// Capture controller: ring-buffer fill with pre/post trigger, then newest-first readout to the UART.
module logip_capture_ctrl
    import logip_pkg::*;
#(
    parameter int unsigned DEPTH     = 5,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic               clk_i,
    input  logic               rst_in,
    logip_capture_ctrl_if.slave bus
);
    localparam int unsigned CW = CNT_WIDTH + 3;
    localparam int unsigned FW = DEPTH + 1;

    cap_state_e           state;
    logic [DEPTH-1:0]     ptr;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        limit;
    logic [CNT_WIDTH-1:0] rd_cnt;
    logic [CNT_WIDTH-1:0] dly_cnt;
    logic [FW-1:0]        fill;

    logic [CW-1:0] post_len;
    logic [CW-1:0] rd_len;
    logic [CW-1:0] fill_ext;
    logic [CW-1:0] limit_nxt;
    logic          post_term;
    logic          rd_term;
    logic          wr;
    logic          fill_clr;

    assign post_len  = CW'(expand_cnt(EXP_WIDTH'(dly_cnt)));
    assign rd_len    = CW'(expand_cnt(EXP_WIDTH'(rd_cnt)));
    assign fill_ext  = CW'(fill);
    // Never read back more samples than were actually written since arming.
    assign limit_nxt = (rd_len < fill_ext) ? rd_len : fill_ext;

    assign post_term = (state == ST_POST) && (cnt == post_len);
    assign rd_term   = (state == ST_RD) && (cnt == limit);
    // The post-trigger terminal cycle takes precedence over a coincident sample.
    assign wr        = !bus.abort_i && bus.stb_i &&
                       ((state == ST_ARMED) || ((state == ST_POST) && !post_term));
    assign fill_clr  = (state == ST_IDLE) && bus.arm_i && !bus.abort_i;

    logip_sat_cnt #(.DEPTH(DEPTH)) u_fill (
        .clk   (clk_i),
        .rst_n (rst_in),
        .clr   (fill_clr),
        .inc   (wr),
        .count (fill)
    );

    assign bus.we_o     = wr;
    assign bus.addr_o   = ptr;
    assign bus.tx_stb_o = (state == ST_TX_STB) && !bus.abort_i;
    assign bus.done_o   = rd_term && !bus.abort_i;
    assign bus.tx_sel_o = (state == ST_RD) || (state == ST_TX_STB) ||
                          (state == ST_TX_BUSY) || (state == ST_TX_WAIT);
    assign bus.busy_o   = (state != ST_IDLE);
    assign bus.armed_o  = (state == ST_ARMED);

    // State machine and pointer/count datapath.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            cnt     <= '0;
            limit   <= '0;
            rd_cnt  <= CNT_WIDTH'(1);
            dly_cnt <= CNT_WIDTH'(1);
        end else if (bus.abort_i) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.set_cnt_i) begin
                        rd_cnt  <= bus.cmd_i[CNT_WIDTH-1:0];
                        dly_cnt <= bus.cmd_i[2*CNT_WIDTH-1:CNT_WIDTH];
                    end
                    if (bus.arm_i) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (bus.stb_i) begin
                        ptr <= ptr + DEPTH'(1);
                    end
                    if (bus.run_i) begin
                        state <= ST_POST;
                        cnt   <= '0;
                    end
                end
                ST_POST: begin
                    if (post_term) begin
                        state <= ST_RD;
                        ptr   <= ptr - DEPTH'(1);
                        cnt   <= '0;
                        limit <= limit_nxt;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (bus.stb_i) begin
                            ptr <= ptr + DEPTH'(1);
                        end
                    end
                end
                ST_RD: begin
                    state <= rd_term ? ST_IDLE : ST_TX_STB;
                end
                ST_TX_STB: begin
                    ptr   <= ptr - DEPTH'(1);
                    cnt   <= cnt + CW'(1);
                    state <= ST_TX_BUSY;
                end
                ST_TX_BUSY: begin
                    if (!bus.tx_rdy_i) begin
                        state <= ST_TX_WAIT;
                    end
                end
                ST_TX_WAIT: begin
                    if (bus.tx_rdy_i) begin
                        state <= ST_RD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/logip_capture_ctrl.md
# logip_capture_ctrl

Second-generation capture controller for the logic analyser core, sitting between the sampler, the sample RAM and the UART transmitter. It adds an explicit arm/abort flow, a saturating fill-level tracker so readback never returns unwritten RAM, and a read handshake aligned to synchronous RAM latency. Depth and counter width are parametrised.

## Interface
- DEPTH, 5, RAM address width; ring holds 2^DEPTH samples
- CNT_WIDTH, 16, width of each count field in the set-count command
- clk_i  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-low
- set_cnt_i  in  1  load count fields from cmd_i
- cmd_i  in  2*CNT_WIDTH  [CNT_WIDTH-1:0] = rd_cnt, upper half = dly_cnt
- arm_i  in  1  start pre-trigger capture
- abort_i  in  1  cancel any activity
- run_i  in  1  trigger
- stb_i  in  1  sample valid
- we_o  out  1  RAM write enable
- addr_o  out  DEPTH  RAM address, write and read
- tx_rdy_i  in  1  transmitter idle
- tx_stb_o  out  1  transmit RAM data, one cycle
- tx_sel_o  out  1  transmitter sources RAM data
- busy_o  out  1  state != IDLE
- armed_o  out  1  state == ARMED
- done_o  out  1  one-cycle pulse when readout completes

## Operation
- States: IDLE, ARMED, POST, RD, TX_STB, TX_BUSY, TX_WAIT.
- Registers: ptr (DEPTH), cnt (CNT_WIDTH+3), fill (DEPTH+1, saturates at 2^DEPTH), limit (CNT_WIDTH+3), rd_cnt, dly_cnt.
- abort_i: highest priority; any state -> IDLE next cycle, no done_o, no write.
- IDLE: no writes. set_cnt_i loads rd_cnt/dly_cnt (ignored in all other states). arm_i -> ARMED, fill <= 0, ptr unchanged. run_i ignored.
- ARMED: stb_i -> we_o=1 at addr_o=ptr, ptr+1 (wraps mod 2^DEPTH), fill+1 saturating. run_i -> POST, cnt <= 0; a same-cycle stb_i is also written.
- POST: if cnt == (dly_cnt+1)<<2 -> RD, ptr <= ptr-1, cnt <= 0, limit <= min((rd_cnt+1)<<2, fill); the terminal check wins, so a same-cycle stb_i is not written. Otherwise stb_i writes as in ARMED, cnt+1.
- RD: if cnt == limit -> IDLE with done_o=1. Otherwise addr_o=ptr (RAM read issued) -> TX_STB.
- TX_STB: tx_stb_o=1, RAM data valid, addr_o held; ptr-1, cnt+1 -> TX_BUSY.
- TX_BUSY: wait for tx_rdy_i=0 -> TX_WAIT.
- TX_WAIT: wait for tx_rdy_i=1 -> RD.
- tx_sel_o = 1 in RD, TX_STB, TX_BUSY, TX_WAIT.
- Arithmetic: (n+1)<<2 evaluated at CNT_WIDTH+3 bits, never overflows. fill zero-extended for the compare. Readback is newest-first, wrapping below address 0.

## Timing
- Reset: state IDLE, ptr 0, cnt 0, fill 0, limit 0, rd_cnt 1, dly_cnt 1. All 1-bit outputs 0; addr_o 0.
- we_o, tx_stb_o and done_o are combinational from state and inputs; all other outputs are registered-state decodes.
- Read latency: addr_o is presented in RD; data is valid in TX_STB, one cycle later.
- Per sample: ≥4 cycles (RD, TX_STB, TX_BUSY ≥1, TX_WAIT ≥1). tx_rdy_i held high never produces a second strobe.
- limit = 0 (fill 0): RD -> IDLE immediately, done_o pulses, no strobe.
- Reset mid-operation: immediate return to reset values; counts revert to 1/1.

## Structure
- Shared package logip_pkg: capture state enum; CMD_WIDTH = 2*CNT_WIDTH default 32; helper function for the (n+1)<<2 expansion.
- One sub-module is natural: logip_sat_cnt, a DEPTH+1 saturating up-counter with clear, used for fill.
- FSM and pointer/count datapath stay in the top module.

## Test plan
- Reset: assert rst_in asynchronously mid-cycle -> all outputs 0, addr_o 0 immediately; after release, busy_o=0.
- Basic: cmd_i=0x0000_0001 (rd 1, dly 0), arm, 10 stb, run, 6 stb -> 4 post writes at 10..13; 8 tx_stb_o at addresses 13 down to 6; done_o pulses once.
- Underfill: cmd_i=0x0000_0003, arm, 2 stb, run, 4 stb -> fill 6, exactly 6 strobes (addresses 5..0), done_o.
- Wrap/saturate: DEPTH 5, cmd_i=0x0000_000F, arm, 40 stb, run, 4 stb -> fill 32, 32 strobes; addresses wrap 11..0, 31..12.
- Handshake/abort: hold tx_rdy_i=1 after first strobe -> no further strobe; then abort_i in TX_WAIT -> IDLE next cycle, tx_sel_o=0, no done_o.
- Precedence: stb_i in the cycle POST reaches terminal -> we_o=0; set_cnt_i or arm_i while ARMED -> ignored.
